// File: rtl/vrf_pkg.sv
// Shared definitions for the vector register file scoreboard: SEW encoding,
// default geometry and legality checks for the VLEN/NREG parameters.
package vrf_pkg;

  localparam int VLEN_DEFAULT = 64;
  localparam int NREG_DEFAULT = 32;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  function automatic bit vlen_legal(input int vlen);
    return (vlen == 64) || (vlen == 128) || (vlen == 256);
  endfunction

  function automatic bit nreg_legal(input int nreg);
    return (nreg == 8) || (nreg == 16) || (nreg == 32);
  endfunction

endpackage

// File: rtl/vrf_mask_expand.sv
// Expands a per-element write mask at a given SEW into per-byte enables.
// Mask bits beyond the element count for that SEW are never referenced.
module vrf_mask_expand
  import vrf_pkg::*;
#(
  parameter  int VLEN = VLEN_DEFAULT,
  localparam int NB   = VLEN / 8
) (
  input  sew_e          sew,
  input  logic [NB-1:0] mask,
  output logic [NB-1:0] be
);

  // Byte b belongs to element b >> sew, so only the low NB >> sew mask bits matter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    be = '0;
    for (int b = 0; b < NB; b++) begin
      unique case (sew)
        SEW_8:  be[b] = mask[b];
        SEW_16: be[b] = mask[b / 2];
        SEW_32: be[b] = mask[b / 4];
        SEW_64: be[b] = mask[b / 8];
        default: be[b] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/vrf_scoreboard.sv
// Vector register file with masked writeback and a busy-bit RAW scoreboard.
// Define VRF_BYPASS_EN to forward the merged writeback value to same-cycle reads.
module vrf_scoreboard
  import vrf_pkg::*;
#(
  parameter  int VLEN = VLEN_DEFAULT,
  parameter  int NREG = NREG_DEFAULT,
  localparam int AW   = $clog2(NREG),
  localparam int NB   = VLEN / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   vs1,
  input  logic [AW-1:0]   vs2,
  input  logic [AW-1:0]   vs3,
  output logic [VLEN-1:0] rdata1,
  output logic [VLEN-1:0] rdata2,
  output logic [VLEN-1:0] rdata3,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [VLEN-1:0] wdata,
  input  logic [1:0]      wsew,
  input  logic [NB-1:0]   wmask,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_vd,
  input  logic            flush,
  output logic [NREG-1:0] busy,
  output logic            raw_stall
);

  if (!vlen_legal(VLEN) || !nreg_legal(NREG)) begin : g_bad_param
    $error("vrf_scoreboard: illegal VLEN or NREG");
  end

  logic [VLEN-1:0] regs [NREG];
  logic [NB-1:0]   wr_be;
  logic [VLEN-1:0] wr_bits;
  logic [VLEN-1:0] wr_merged;
  logic            wr_act;
  logic            iss_act;

  assign wr_act  = wen && (waddr != '0);
  assign iss_act = iss_valid && (iss_vd != '0);

  vrf_mask_expand #(.VLEN(VLEN)) u_mask_expand (
    .sew  (sew_e'(wsew)),
    .mask (wmask),
    .be   (wr_be)
  );

  always_comb begin
    wr_bits = '0;
    for (int b = 0; b < NB; b++) begin
      wr_bits[b*8 +: 8] = {8{wr_be[b]}};
    end
  end

  // Post-write image of the destination; feeds both the array and the bypass.
  assign wr_merged = (regs[waddr] & ~wr_bits) | (wdata & wr_bits);

  // NOTE: the register array is plain flops, not a RAM macro, so it can and must
  // clear on reset; a RAM-backed variant would need a clear sequence instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_act) begin
      regs[waddr] <= wr_merged;
    end
  end

  function automatic logic [VLEN-1:0] read_port(input logic [AW-1:0] idx);
    logic [VLEN-1:0] val;
    val = (idx == '0) ? '0 : regs[idx];
`ifdef VRF_BYPASS_EN
    if (wr_act && (idx == waddr)) begin
      val = wr_merged;
    end
`endif
    return val;
  endfunction

  always_comb begin
    rdata1 = read_port(vs1);
    rdata2 = read_port(vs2);
    rdata3 = read_port(vs3);
  end

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] busy_view;

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (wr_act) begin
      clr_vec[waddr] = 1'b1;
    end
    if (iss_act) begin
      set_vec[iss_vd] = 1'b1;
    end
    // Set after clear so a same-cycle issue keeps its reservation; flush beats both.
    busy_nxt = flush ? '0 : ((busy_q & ~clr_vec) | set_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy = busy_q;

`ifdef VRF_BYPASS_EN
  assign busy_view = busy_q & ~clr_vec;
`else
  assign busy_view = busy_q;
`endif

  assign raw_stall = ((vs1 != '0) && busy_view[vs1]) ||
                     ((vs2 != '0) && busy_view[vs2]) ||
                     ((vs3 != '0) && busy_view[vs3]);

endmodule
